cla_result_fifo: RTL and testbench

Output-side collection stage for the 4-bit carry-lookahead adder datapath. Accepts one registered result per cycle (sum plus carry-out) from the adder pipeline, buffers it in a small FIFO, and presents it to the downstream consumer over a valid/ready handshake. The adder front end cannot be stalled, so a result that arrives while the buffer is full is dropped and counted in a saturating drop counter.

---
 rtl/cla_result_fifo.sv | 83 ++++++++
 tb/tb_cla_result_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cla_result_fifo.sv
// Result buffer behind the carry-lookahead adder: stores {cout, sum} entries and
// hands them downstream over valid/ready; results arriving while full are dropped and counted.
module cla_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_cout,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            full, empty, push, pop, drop;
  logic [WIDTH:0]  head;

  always_comb begin
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    push       = in_valid && !full;
    pop        = !empty && out_ready;
    // A full buffer drops even when the head leaves in the same cycle.
    drop       = in_valid && full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_cout, in_sum};
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    in_ready  = !full;
    out_valid = !empty;
    out_sum   = empty ? '0 : head[WIDTH-1:0];
    out_cout  = empty ? 1'b0 : head[WIDTH];
    count     = count_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_cla_result_fifo.sv
// Scoreboard bench for cla_result_fifo: stimulus queues expected entries, a negedge
// monitor pops and compares whenever the consumer takes the head.
module tb_cla_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_sum;
  logic       in_cout;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_sum;
  logic       out_cout;
  logic       out_ready;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int m_count = 0;
  int m_drop = 0;
  logic [4:0] exp_q [$];

  cla_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready),
    .out_valid(out_valid), .out_sum(out_sum), .out_cout(out_cout), .out_ready(out_ready),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides push/pop/drop from occupancy before the edge.
  task automatic cycle(input logic v, input logic [3:0] s, input logic c, input logic r);
    bit p_push, p_pop, p_drop;
    in_valid = v; in_sum = s; in_cout = c; out_ready = r;
    p_push = v && (m_count < 4);
    p_pop  = (m_count != 0) && r;
    p_drop = v && (m_count == 4);
    if (p_push) exp_q.push_back({c, s});
    @(posedge clk); #1;
    m_count = m_count + int'(p_push) - int'(p_pop);
    if (p_drop && m_drop < 255) m_drop++;
  endtask

  task automatic model_reset();
    m_count = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_cout"}, out_cout, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (!reset) begin
      chk("count", count, m_count);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("in_ready", in_ready, int'(m_count < 4));
      chk("out_valid", out_valid, int'(m_count != 0));
      if (m_count == 0) begin
        chk("idle_sum", out_sum, 0);
        chk("idle_cout", out_cout, 0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow got pop with %0d queued want >0", exp_q.size());
        end else begin
          e = exp_q.pop_front();
          chk("head_entry", {out_cout, out_sum}, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_sum = 0; in_cout = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-cycle with entries buffered and random inputs on the pins.
    cycle(1, 4'h1, 0, 0);
    cycle(1, 4'h2, 1, 0);
    in_valid = 1'($urandom); in_sum = 4'($urandom); in_cout = 1'($urandom);
    out_ready = 1'($urandom);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) cycle(0, 4'h0, 0, 1);
    chk_reset_outputs("idle");

    // Single pass-through: visible the cycle after the push, popped on the next edge.
    cycle(1, 4'hA, 1, 1);
    chk("pass_valid", out_valid, 1);
    chk("pass_data", {out_cout, out_sum}, 5'h1A);
    cycle(0, 4'h0, 0, 1);
    chk("pass_count", count, 0);

    // Fill and drop.
    cycle(1, 4'h3, 0, 0);
    cycle(1, 4'h7, 1, 0);
    cycle(1, 4'hB, 0, 0);
    cycle(1, 4'hF, 1, 0);
    cycle(1, 4'h2, 0, 0);
    cycle(1, 4'h5, 1, 0);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_drop_cnt", drop_cnt, 2);
    repeat (5) cycle(0, 4'h0, 0, 1);
    chk("drain_count", count, 0);

    // Full with simultaneous pop: head leaves, incoming 9 is still dropped.
    cycle(1, 4'h1, 0, 0);
    cycle(1, 4'h4, 1, 0);
    cycle(1, 4'h6, 0, 0);
    cycle(1, 4'h8, 1, 0);
    cycle(1, 4'h9, 0, 1);
    chk("fullpop_count", count, 3);
    chk("fullpop_drop_cnt", drop_cnt, 3);
    repeat (4) cycle(0, 4'h0, 0, 1);

    // Wrap-around streaming.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] s;
      s = 4'(i);
      cycle(1, s, s[0], 1);
      chk("stream_count_le1", int'(count <= 3'd1), 1);
    end
    cycle(0, 4'h0, 0, 1);
    chk("stream_end_count", count, 0);
    chk("stream_drop_cnt", drop_cnt, 3);

    // Drop-counter saturation with a held-full buffer.
    cycle(1, 4'h5, 1, 0);
    cycle(1, 4'h6, 0, 0);
    cycle(1, 4'hC, 1, 0);
    cycle(1, 4'hD, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 4'(i), 1'(i), 0);
    chk("sat_drop_cnt", drop_cnt, 255);
    chk("sat_count", count, 4);
    repeat (4) cycle(0, 4'h0, 0, 1);
    chk("sat_drained", count, 0);

    // Reset mid-stream.
    cycle(1, 4'h3, 1, 0);
    cycle(1, 4'h4, 0, 0);
    in_valid = 1; in_sum = 4'hE; in_cout = 1; out_ready = 1;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midstream_reset");
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) cycle(0, 4'h0, 0, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
